// File: rtl/lc3b_types.sv
// Shared line-level types for the LC-3b cache and its physical-memory backend.
//   lc3b_pmem_line : one 128-bit memory line, the unit moved on pmem_rdata/pmem_wdata
//   LINE_OFFSET_W  : byte-offset bits within a line (ignored by line-granular memory)
package lc3b_types;

    localparam int unsigned LINE_OFFSET_W = 4;

    typedef logic [127:0] lc3b_pmem_line;

endpackage : lc3b_types

// File: rtl/pmem_responder_pkg.sv
// Responder-local definitions: FSM state encoding and latency-counter width.
package pmem_responder_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } pmem_state_e;

endpackage : pmem_responder_pkg

// File: rtl/pmem_responder_array.sv
// Single-port line RAM with a registered read port.
//   clk      : clock
//   rst_n    : synchronous active-low reset (clears only the read register)
//   we_i     : write enable, writes wdata_i to line idx_i
//   re_i     : read enable, loads line idx_i into the read register
//   idx_i    : line index
//   wdata_i  : write line
//   rdata_o  : registered read line, held until the next read
module pmem_responder_array
    import lc3b_types::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] idx_i,
    input  lc3b_pmem_line    wdata_i,
    output lc3b_pmem_line    rdata_o
);

    lc3b_pmem_line mem_q [0:(1<<IDX_W)-1];
    lc3b_pmem_line rdata_q;

    // Line storage: never cleared; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (we_i && rst_n) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register: cleared by reset, otherwise updated only on a read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 128'd0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : pmem_responder_array

// File: rtl/pmem_responder.sv
// Physical-memory responder for the cache's line-granular pmem handshake.
// Accepts a read or write, waits LATENCY cycles, commits, then pulses pmem_resp.
//   clk, rst_n     : clock, synchronous active-low reset
//   pmem_address   : byte address; [3:0] ignored, [4 +: IDX_W] selects the line
//   pmem_read/write: level requests held until pmem_resp
//   pmem_wdata     : write line
//   pmem_rdata     : registered read line, valid in the resp cycle and held after
//   pmem_resp      : one-cycle completion pulse
//   proto_err      : sticky, read and write seen together at an accepting edge
//   rd_count/wr_count : saturating completion counters
module pmem_responder
    import lc3b_types::*;
    import pmem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned IDX_W   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   pmem_address,
    input  logic          pmem_read,
    input  logic          pmem_write,
    input  lc3b_pmem_line pmem_wdata,
    output lc3b_pmem_line pmem_rdata,
    output logic          pmem_resp,
    output logic          proto_err,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    pmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_wr_q, op_wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    lc3b_pmem_line    wdata_q, wdata_d;
    logic             resp_q, resp_d;
    logic             proto_q, proto_d;
    logic [15:0]      rd_count_q, rd_count_d;
    logic [15:0]      wr_count_q, wr_count_d;

    logic             strobe_s;
    logic             commit_wr_s;
    logic             commit_rd_s;
    logic             unused_addr_s;

    // Offset and aliasing bits of the address are intentionally dropped.
    assign unused_addr_s = ^pmem_address;

    // Only the latched op's strobe matters once busy; everything else is ignored.
    assign strobe_s = op_wr_q ? pmem_write : pmem_read;

    // Next-state, latch and commit decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        resp_d      = 1'b0;
        proto_d     = proto_q;
        commit_wr_s = 1'b0;
        commit_rd_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pmem_read || pmem_write) begin
                    // A simultaneous read+write is resolved as a write.
                    op_wr_d = pmem_write;
                    idx_d   = pmem_address[LINE_OFFSET_W +: IDX_W];
                    wdata_d = pmem_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                    if (pmem_read && pmem_write) begin
                        proto_d = 1'b1;
                    end else begin
                        proto_d = proto_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!strobe_s) begin
                    // Initiator withdrew: abort without side effects.
                    state_d = ST_IDLE;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d     = ST_RESP;
                    resp_d      = 1'b1;
                    commit_wr_s = op_wr_q;
                    commit_rd_s = !op_wr_q;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating completion counters.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (commit_rd_s && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end else begin
            rd_count_d = rd_count_q;
        end
        if (commit_wr_s && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Control and statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            op_wr_q    <= 1'b0;
            idx_q      <= {IDX_W{1'b0}};
            wdata_q    <= 128'd0;
            resp_q     <= 1'b0;
            proto_q    <= 1'b0;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            proto_q    <= proto_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    pmem_responder_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (commit_wr_s),
        .re_i    (commit_rd_s),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (pmem_rdata)
    );

    assign pmem_resp = resp_q;
    assign proto_err = proto_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule : pmem_responder

// File: doc/pmem_responder.md
# pmem_responder

Synthesizable physical-memory responder that answers the cache's line-granular pmem_read/pmem_write handshake. It sits below the cache controller, latches each request, and waits a parameterized number of cycles. It then commits a write or returns a line of read data with a one-cycle pmem_resp pulse. It backs simulation and FPGA builds, and is the reference target the cache is verified against.

## Interface
- LATENCY, 4: cycles from request accept to pmem_resp; legal range 1..255.
- IDX_W, 8: line-index width; the array holds 2^IDX_W lines of 128 bits.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pmem_address  in  16  byte address; bits [3:0] are line offset and are ignored; bits [4 +: IDX_W] select the line; upper bits alias.
- pmem_read  in  1  line read request, level, held until pmem_resp.
- pmem_write  in  1  line write request, level, held until pmem_resp.
- pmem_wdata  in  128  write line.
- pmem_rdata  out  128  read line; registered.
- pmem_resp  out  1  one-cycle completion pulse.
- proto_err  out  1  sticky flag: pmem_read and pmem_write were high together at an accepting edge.
- rd_count, wr_count  out  16 each  completed reads/writes; saturating at 16'hFFFF.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: at an edge where pmem_read or pmem_write is high:
  - latch op, index and wdata;
  - load cnt = LATENCY-1;
  - go to BUSY.
- Both requests high at that edge: treated as a write; proto_err sets to 1.
- BUSY: request inputs other than the latched op's strobe are ignored, including address and wdata changes.
  - Latched op's strobe low at an edge: abort. Go to IDLE, no commit, no resp, counters unchanged.
  - Otherwise, if cnt==0, go to RESP and on that same edge commit:
    - write: array[idx] <= latched wdata; wr_count++.
    - read: pmem_rdata <= array[idx]; rd_count++.
  - Otherwise cnt--.
- RESP: pmem_resp=1 for this cycle only. Next state is always IDLE, and no request is sampled in RESP.
- pmem_rdata holds its value until the next completed read. Writes and aborts do not change it.
- Read-after-write to the same line returns the new data. Writes commit before any later accept.
- Reset, including mid-BUSY or in RESP:
  - state=IDLE, cnt=0, pmem_resp=0, pmem_rdata=0, proto_err=0, rd_count=0, wr_count=0;
  - any in-flight write is discarded;
  - array contents are not cleared.
- Array contents are undefined after power-up. Bench preloads via hierarchical access or a write sweep.

## Timing
- Request first sampled high at edge t → pmem_resp high in the cycle following edge t+LATENCY.
  - Example: LATENCY=1 → resp after edge t+1.
- pmem_rdata is valid in the pmem_resp cycle and stays stable afterward.
- Turnaround: after the resp cycle there is one IDLE cycle. A request raised in the cycle after resp is sampled at the end of that IDLE cycle.
  - The cache's write_back→read_in sequence therefore sees the read accepted 1 cycle after the write's resp, and its own resp LATENCY cycles after that.
- A request still high during RESP (the initiator has not yet dropped it) is not re-accepted. The initiator must drop it in the cycle after resp. If it stays high into IDLE it is accepted as a new transaction; this is documented initiator behaviour, not an error.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- lc3b_types holds the 128-bit line typedef (lc3b_pmem_line) and the LINE_OFFSET_W=4 constant. The responder and the cache datapath share both.
- Sub-module pmem_array:
  - single-port 2^IDX_W × 128 synchronous RAM;
  - write-enable plus registered read;
  - holds the array and the rdata register.
- The FSM, counter and statistics live in pmem_responder.

## Test plan
- Reset, then preload line 5 with 128'hA5.., then pmem_read addr 16'h0050 held → pmem_resp exactly one cycle, 4 cycles after accept; pmem_rdata=128'hA5..; rd_count=1.
- Write line 16'h0120 with 128'h1234.. then read the same address → read returns 128'h1234..; wr_count=1, rd_count=1.
- Write_back→read_in emulation: write addr 16'h0300, then raise read 16'h0410 the cycle after resp → read accepted 1 cycle later; total 2*LATENCY+2 cycles from first accept to second resp.
- Drop pmem_write in BUSY cycle 2 → no resp; a read of that line returns the old data; wr_count unchanged.
- Assert rst_n=0 in BUSY of a write → all outputs 0 the next cycle; line unchanged; a fresh read completes normally.
- pmem_read and pmem_write both high with addr 16'h0070 → proto_err=1 until reset; line 7 written; wr_count increments, rd_count does not.
